mycpu_trace_buffer: RTL

Synthesizable, parametrised bus-trace recorder for the mycpu core. It snoops the CPU memory/IO bus (a_out, d_out, wen_out, iom_out) and stores qualified bus cycles, each with a timestamp, in a circular buffer. Capture stops on a programmable trigger plus a programmable number of post-trigger entries. This replaces free-running simulation-only logging with on-chip capture that behaves the same in RTL, gate and post-layout runs, and is read back through a simple indexed read port.

---
 rtl/mycpu_pkg.sv | 31 +++
 rtl/mycpu_trace_mem.sv | 28 ++
 rtl/mycpu_trace_buffer.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/mycpu_pkg.sv
// Shared types for the mycpu trace buffer: capture states, trigger modes and
// the packed trace entry layout {ts, iom, wen, a, d} at default widths.
package mycpu_pkg;

  localparam int unsigned TRACE_AW  = 16;
  localparam int unsigned TRACE_DW  = 16;
  localparam int unsigned TRACE_TSW = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_POST = 2'd2,
    ST_DONE = 2'd3
  } trace_state_t;

  typedef enum logic [1:0] {
    TRIG_MANUAL     = 2'd0,
    TRIG_ADDR_MATCH = 2'd1,
    TRIG_IO_WRITE   = 2'd2,
    TRIG_ANY_WRITE  = 2'd3
  } trig_mode_t;

  typedef struct packed {
    logic [TRACE_TSW-1:0] ts;
    logic                 iom;
    logic                 wen;
    logic [TRACE_AW-1:0]  a;
    logic [TRACE_DW-1:0]  d;
  } trace_entry_t;

endpackage

// File: rtl/mycpu_trace_mem.sv
// Simple dual-port trace RAM: one write port, one registered read port.
// No reset on the array so a memory macro can replace it directly.
module mycpu_trace_mem #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned EW    = 50,
  localparam int unsigned PW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [PW-1:0] i_waddr,
  input  logic [EW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [PW-1:0] i_raddr,
  output logic [EW-1:0] o_rdata
);

  logic [EW-1:0] r_mem [DEPTH];
  logic [EW-1:0] r_q;

  // Read-before-write: a same-slot read returns the old contents.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_q <= r_mem[i_raddr];
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/mycpu_trace_buffer.sv
// Bus-trace recorder: snoops the CPU bus into a circular buffer, stops after a
// programmable trigger plus post-trigger entries, read back by relative index.
module mycpu_trace_buffer
  import mycpu_pkg::*;
#(
  parameter int unsigned AW    = 16,
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned TSW   = 16,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned EW   = TSW + 2 + AW + DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] a_in,
  input  logic [DW-1:0] d_in,
  input  logic          wen_in,
  input  logic          iom_in,
  input  logic          arm_in,
  input  logic          filter_in,
  input  logic [1:0]    trig_mode_in,
  input  logic [AW-1:0] trig_addr_in,
  input  logic          manual_trig_in,
  input  logic [PW:0]   post_count_in,
  input  logic          rd_en_in,
  input  logic [PW-1:0] rd_idx_in,
  output logic [EW-1:0] rd_data_out,
  output logic          rd_valid_out,
  output logic [1:0]    state_out,
  output logic [PW:0]   count_out,
  output logic [PW-1:0] trig_idx_out
);

  localparam logic [PW:0]   DEPTH_V  = (PW+1)'(DEPTH);
  localparam logic [PW:0]   DEPTH_M1 = (PW+1)'(DEPTH - 1);
  localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);

  trace_state_t  r_state;
  logic [PW-1:0] r_wr_ptr;
  logic [PW:0]   r_count;
  logic [TSW-1:0] r_ts;
  logic [PW-1:0] r_post_left;
  logic [PW-1:0] r_post_cfg;
  logic [PW-1:0] r_trig_idx;
  logic          r_rd_valid;
  logic          r_rd_zero;

  logic          w_capturing;
  logic          w_qual;
  logic          w_hit;
  logic          w_full;
  logic [PW-1:0] w_post_clamp;
  logic [PW-1:0] w_oldest;
  logic [PW-1:0] w_rd_addr;
  logic          w_rd_oor;
  logic [EW-1:0] w_wdata;
  logic [EW-1:0] w_mem_q;

  assign w_capturing  = (r_state == ST_PRE) || (r_state == ST_POST);
  assign w_qual       = w_capturing && !arm_in && (!filter_in || !wen_in || iom_in);
  assign w_full       = (r_count == DEPTH_V);
  assign w_post_clamp = (post_count_in > DEPTH_M1) ? LAST_IDX : post_count_in[PW-1:0];
  assign w_oldest     = r_wr_ptr - r_count[PW-1:0];
  assign w_rd_addr    = w_oldest + rd_idx_in;
  assign w_rd_oor     = ({1'b0, rd_idx_in} >= r_count);
  assign w_wdata      = {r_ts, iom_in, wen_in, a_in, d_in};

  // Trigger qualification by mode; only consulted on qualified PRE cycles.
  always_comb begin
    w_hit = 1'b0;
    case (trig_mode_t'(trig_mode_in))
      TRIG_MANUAL:     w_hit = manual_trig_in;
      TRIG_ADDR_MATCH: w_hit = (a_in == trig_addr_in);
      TRIG_IO_WRITE:   w_hit = iom_in && !wen_in;
      TRIG_ANY_WRITE:  w_hit = !wen_in;
      default:         w_hit = 1'b0;
    endcase
  end

  // Capture FSM, pointers and timestamp. The trigger index is tracked
  // relative to the oldest entry and slides down whenever the oldest is evicted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_ts        <= '0;
      r_post_left <= '0;
      r_post_cfg  <= '0;
      r_trig_idx  <= '0;
    end else if (arm_in) begin
      r_state     <= ST_PRE;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_ts        <= '0;
      r_post_left <= '0;
      r_post_cfg  <= w_post_clamp;
      r_trig_idx  <= '0;
    end else if (w_capturing) begin
      r_ts <= r_ts + TSW'(1);
      if (w_qual) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
        if (!w_full) r_count <= r_count + (PW+1)'(1);
        if (r_state == ST_PRE) begin
          if (w_hit) begin
            r_trig_idx <= w_full ? LAST_IDX : r_count[PW-1:0];
            if (r_post_cfg == '0) begin
              r_state <= ST_DONE;
            end else begin
              r_state     <= ST_POST;
              r_post_left <= r_post_cfg;
            end
          end
        end else begin
          if (w_full) r_trig_idx <= r_trig_idx - PW'(1);
          r_post_left <= r_post_left - PW'(1);
          if (r_post_left == PW'(1)) r_state <= ST_DONE;
        end
      end
    end
  end

  // Read side: one-cycle latency, out-of-range indices read as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_zero  <= 1'b1;
    end else begin
      r_rd_valid <= rd_en_in;
      if (rd_en_in) r_rd_zero <= w_rd_oor;
    end
  end

  mycpu_trace_mem #(
    .DEPTH (DEPTH),
    .EW    (EW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_qual),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wdata),
    .i_re    (rd_en_in),
    .i_raddr (w_rd_addr),
    .o_rdata (w_mem_q)
  );

  assign rd_data_out  = r_rd_zero ? '0 : w_mem_q;
  assign rd_valid_out = r_rd_valid;
  assign state_out    = r_state;
  assign count_out    = r_count;
  assign trig_idx_out = r_trig_idx;

endmodule
